// File: rtl/lcd_controller.sv
// Write-only HD44780 sequencer: power-up init, then one byte per
// valid/ready handshake with setup/pulse/hold/exec timing on the E strobe.
module lcd_controller #(
    parameter int unsigned POWERUP_CYCLES = 375000,
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned PULSE_CYCLES   = 6,
    parameter int unsigned HOLD_CYCLES    = 2,
    parameter int unsigned EXEC_CYCLES    = 1000,
    parameter int unsigned CLEAR_CYCLES   = 41000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    localparam int unsigned MAX_A =
        (POWERUP_CYCLES > CLEAR_CYCLES) ? POWERUP_CYCLES : CLEAR_CYCLES;
    localparam int unsigned MAX_B =
        (EXEC_CYCLES > PULSE_CYCLES) ? EXEC_CYCLES : PULSE_CYCLES;
    localparam int unsigned MAX_C =
        (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_ALL = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int unsigned CW = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] POWERUP_LD = CW'(POWERUP_CYCLES - 1);
    localparam logic [CW-1:0] SETUP_LD   = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LD   = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] EXEC_LD    = CW'(EXEC_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_LD   = CW'(CLEAR_CYCLES - 1);

    if (POWERUP_CYCLES < 1 || SETUP_CYCLES < 1 || PULSE_CYCLES < 1 ||
        HOLD_CYCLES < 1 || EXEC_CYCLES < 1 || CLEAR_CYCLES < 1)
    begin : g_param_check
        $error("lcd_controller: every cycle parameter must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT_LOAD,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          cnt_zero;
    logic [1:0]    init_idx;
    logic          init_last;
    logic [7:0]    init_cmd;
    logic          load_init;
    logic          load_req;
    logic          set_done;
    logic          is_clear;

    assign lcd_rw   = 1'b0;
    assign cnt_zero = (cnt == '0);

    // Clear and return-home need the long execution wait.
    assign is_clear = !lcd_rs &&
        (lcd_data[7:1] == 7'b0000000 || lcd_data[7:1] == 7'b0000001);

    always_comb begin
        init_cmd = 8'h38;
        unique case (init_idx)
            2'd0: init_cmd = 8'h38;
            2'd1: init_cmd = 8'h0C;
            2'd2: init_cmd = 8'h01;
            2'd3: init_cmd = 8'h06;
            default: init_cmd = 8'h38;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_POWERUP;
            cnt   <= POWERUP_LD;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        load_init = 1'b0;
        load_req  = 1'b0;
        set_done  = 1'b0;
        req_ready = 1'b0;
        unique case (state)
            ST_POWERUP: begin
                if (cnt_zero) begin
                    state_n = ST_INIT_LOAD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_INIT_LOAD: begin
                load_init = 1'b1;
                state_n   = ST_SETUP;
                cnt_n     = SETUP_LD;
            end
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    load_req = 1'b1;
                    state_n  = ST_SETUP;
                    cnt_n    = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_n = ST_PULSE;
                    cnt_n   = PULSE_LD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_zero) begin
                    state_n = ST_HOLD;
                    cnt_n   = HOLD_LD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_n = ST_WAIT;
                    cnt_n   = is_clear ? CLEAR_LD : EXEC_LD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_WAIT: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - CW'(1);
                end else if (init_done) begin
                    state_n = ST_IDLE;
                end else if (init_last) begin
                    state_n  = ST_IDLE;
                    set_done = 1'b1;
                end else begin
                    state_n = ST_INIT_LOAD;
                end
            end
            default: begin
                state_n = ST_POWERUP;
                cnt_n   = POWERUP_LD;
            end
        endcase
    end

    // E is registered from the next state so the pin never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
            init_idx  <= 2'd0;
            init_last <= 1'b0;
            init_done <= 1'b0;
        end else begin
            lcd_e <= (state_n == ST_PULSE);
            if (set_done) begin
                init_done <= 1'b1;
            end
            if (load_init) begin
                lcd_rs    <= 1'b0;
                lcd_data  <= init_cmd;
                init_idx  <= init_idx + 2'd1;
                init_last <= (init_idx == 2'd3);
            end
            if (load_req) begin
                lcd_rs   <= req_rs;
                lcd_data <= req_data;
            end
        end
    end

endmodule
